ecc_163_err_monitor: RTL and testbench

//  Downstream stage of the 163-bit ECC fault-detect stage on the FIFO read path. Registers corrected

---
 rtl/ecc_163_err_monitor.sv | 121 ++++++++++++
 tb/tb_ecc_163_err_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ecc_163_err_monitor.sv
// Error monitor behind the 163-bit ECC stage: registers read data and keeps saturating
// event counters, a first-error capture (address/type), a sticky overflow flag and a level irq.
module ecc_163_err_monitor #(
   parameter int DATA_WIDTH = 163,
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_vld,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  sbit_err,
   input  logic                  dbit_err,
   input  logic                  ecc_fault,
   input  logic                  irq_en,
   input  logic                  clr,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_err,
   output logic [CNT_WIDTH-1:0]  sbit_cnt,
   output logic [CNT_WIDTH-1:0]  dbit_cnt,
   output logic [CNT_WIDTH-1:0]  fault_cnt,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic [1:0]            first_err_type,
   output logic                  err_ovf,
   output logic                  irq,
   output logic                  fsm_state
);

   // Handshake: rd_vld qualifies rd_addr/data_in/flags for exactly one cycle; there is no
   // ready, the monitor accepts every valid word. out_vld is rd_vld delayed by one cycle.

   typedef enum logic {
      IDLE     = 1'b0,
      CAPTURED = 1'b1
   } state_t;

   state_t                state_q, state_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [1:0]            type_n;
   logic                  ovf_n;
   logic                  irq_n;
   logic                  any_err;
   logic [1:0]            ev_type;
   logic [CNT_WIDTH-1:0]  sbit_n, dbit_n, fault_n;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic                  hit);
      if (hit && (cnt != {CNT_WIDTH{1'b1}}))
         return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      return cnt;
   endfunction

   assign fsm_state = state_q;

   always_comb begin
      any_err = rd_vld & (sbit_err | dbit_err | ecc_fault);
      if (ecc_fault)     ev_type = 2'd3;
      else if (dbit_err) ev_type = 2'd2;
      else if (sbit_err) ev_type = 2'd1;
      else               ev_type = 2'd0;
   end

   // clr forms the base state; a simultaneous valid error is then applied on top of it.
   always_comb begin
      state_n = clr ? IDLE : state_q;
      addr_n  = clr ? '0 : first_err_addr;
      type_n  = clr ? 2'd0 : first_err_type;
      ovf_n   = clr ? 1'b0 : err_ovf;
      if (any_err) begin
         if (state_n == IDLE) begin
            addr_n  = rd_addr;
            type_n  = ev_type;
            state_n = CAPTURED;
         end else begin
            ovf_n = 1'b1;
         end
      end
      irq_n   = (state_n == CAPTURED) & irq_en;
      sbit_n  = sat_inc(clr ? '0 : sbit_cnt,  rd_vld & sbit_err);
      dbit_n  = sat_inc(clr ? '0 : dbit_cnt,  rd_vld & dbit_err);
      fault_n = sat_inc(clr ? '0 : fault_cnt, rd_vld & ecc_fault);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         first_err_addr <= '0;
         first_err_type <= 2'd0;
         err_ovf        <= 1'b0;
         irq            <= 1'b0;
         sbit_cnt       <= '0;
         dbit_cnt       <= '0;
         fault_cnt      <= '0;
      end else begin
         state_q        <= state_n;
         first_err_addr <= addr_n;
         first_err_type <= type_n;
         err_ovf        <= ovf_n;
         irq            <= irq_n;
         sbit_cnt       <= sbit_n;
         dbit_cnt       <= dbit_n;
         fault_cnt      <= fault_n;
      end
   end

   // Data path is independent of clr; data_out holds across idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         data_out <= '0;
         out_err  <= 1'b0;
      end else begin
         out_vld <= rd_vld;
         out_err <= rd_vld & (dbit_err | ecc_fault);
         if (rd_vld) data_out <= data_in;
      end
   end

endmodule

// File: tb/tb_ecc_163_err_monitor.sv
// Directed bench for ecc_163_err_monitor: a default-width instance plus a CNT_WIDTH=4 instance
// sharing the same stimulus, so counter saturation can be reached in a few cycles.
module tb_ecc_163_err_monitor;

   localparam int DW = 163;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_vld;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] data_in;
   logic          sbit_err, dbit_err, ecc_fault, irq_en, clr;

   logic          out_vld, out_err, err_ovf, irq, fsm_state;
   logic [DW-1:0] data_out;
   logic [15:0]   sbit_cnt, dbit_cnt, fault_cnt;
   logic [AW-1:0] first_err_addr;
   logic [1:0]    first_err_type;

   logic          s_out_vld, s_out_err, s_err_ovf, s_irq, s_fsm_state;
   logic [DW-1:0] s_data_out;
   logic [3:0]    s_sbit_cnt, s_dbit_cnt, s_fault_cnt;
   logic [AW-1:0] s_first_err_addr;
   logic [1:0]    s_first_err_type;

   int            pass_cnt = 0;
   int            check_cnt = 0;
   logic [DW-1:0] exp_data;

   // clock / reset
   always #5 clk = ~clk;

   ecc_163_err_monitor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .rd_vld(rd_vld), .rd_addr(rd_addr), .data_in(data_in),
      .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault), .irq_en(irq_en),
      .clr(clr), .out_vld(out_vld), .data_out(data_out), .out_err(out_err),
      .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
      .first_err_addr(first_err_addr), .first_err_type(first_err_type),
      .err_ovf(err_ovf), .irq(irq), .fsm_state(fsm_state)
   );

   ecc_163_err_monitor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) u_small (
      .clk(clk), .rst_n(rst_n), .rd_vld(rd_vld), .rd_addr(rd_addr), .data_in(data_in),
      .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault), .irq_en(irq_en),
      .clr(clr), .out_vld(s_out_vld), .data_out(s_data_out), .out_err(s_out_err),
      .sbit_cnt(s_sbit_cnt), .dbit_cnt(s_dbit_cnt), .fault_cnt(s_fault_cnt),
      .first_err_addr(s_first_err_addr), .first_err_type(s_first_err_type),
      .err_ovf(s_err_ovf), .irq(s_irq), .fsm_state(s_fsm_state)
   );

   typedef struct {
      logic        vld;
      logic [7:0]  addr;
      logic        sb, db, ft, en, cl;
      logic        e_vld, e_err;
      logic [15:0] e_sb, e_db, e_ft;
      logic [7:0]  e_addr;
      logic [1:0]  e_type;
      logic        e_ovf, e_irq;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [DW-1:0] pat(input int i);
      logic [191:0] t;
      t = {6{32'hC0DE_0000 | 32'(i)}};
      return t[DW-1:0];
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // driver tasks
   task automatic drive(input logic vld, input logic [7:0] addr, input logic sb, input logic db,
                        input logic ft, input logic en, input logic cl, input int tag);
      rd_vld = vld; rd_addr = addr; sbit_err = sb; dbit_err = db; ecc_fault = ft;
      irq_en = en; clr = cl;
      data_in = pat(tag);
      if (vld) exp_data = pat(tag);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic e_vld, input logic e_err,
                              input logic [15:0] e_sb, input logic [15:0] e_db,
                              input logic [15:0] e_ft, input logic [7:0] e_addr,
                              input logic [1:0] e_type, input logic e_ovf, input logic e_irq);
      check({tag, " out_vld"}, DW'(out_vld), DW'(e_vld));
      check({tag, " out_err"}, DW'(out_err), DW'(e_err));
      check({tag, " data_out"}, data_out, exp_data);
      check({tag, " sbit_cnt"}, DW'(sbit_cnt), DW'(e_sb));
      check({tag, " dbit_cnt"}, DW'(dbit_cnt), DW'(e_db));
      check({tag, " fault_cnt"}, DW'(fault_cnt), DW'(e_ft));
      check({tag, " first_err_addr"}, DW'(first_err_addr), DW'(e_addr));
      check({tag, " first_err_type"}, DW'(first_err_type), DW'(e_type));
      check({tag, " err_ovf"}, DW'(err_ovf), DW'(e_ovf));
      check({tag, " irq"}, DW'(irq), DW'(e_irq));
   endtask

   task automatic check_all_zero(input string tag);
      exp_data = '0;
      check_state(tag, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'h00, 2'd0, 1'b0, 1'b0);
      check({tag, " small out_vld"}, DW'(s_out_vld), '0);
      check({tag, " small data_out"}, s_data_out, '0);
      check({tag, " small sbit_cnt"}, DW'(s_sbit_cnt), '0);
      check({tag, " small first_err_type"}, DW'(s_first_err_type), '0);
      check({tag, " small err_ovf"}, DW'(s_err_ovf), '0);
      check({tag, " small irq"}, DW'(s_irq), '0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0, 16'd0, 8'h12, 2'd1, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 16'd0, 8'h12, 2'd1, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 8'h56, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1, 16'd0, 8'h12, 2'd1, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1, 16'd0, 8'h12, 2'd1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 8'h00, 2'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 16'd1, 8'h05, 2'd3, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd2, 16'd1, 8'h05, 2'd3, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd3, 16'd1, 8'h05, 2'd3, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd4, 16'd1, 8'h05, 2'd3, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 8'h23, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 16'd5, 16'd1, 8'h05, 2'd3, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 16'd1, 16'd0, 8'h7F, 2'd2, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1, 16'd0, 8'h7F, 2'd2, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 16'd1, 8'h7F, 2'd2, 1'b1, 1'b0};

      rst_n = 1'b0;
      exp_data = '0;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (2) step();
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // clean reads: out_vld echoes rd_vld one cycle late
      for (int i = 0; i < 10; i++) begin
         drive((i % 3) != 0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 100 + i);
         step();
         check_state($sformatf("clean%0d", i), (i % 3) != 0, 1'b0, 16'd0, 16'd0, 16'd0,
                     8'h00, 2'd0, 1'b0, 1'b0);
      end

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].vld, vecs[i].addr, vecs[i].sb, vecs[i].db, vecs[i].ft, vecs[i].en,
               vecs[i].cl, 200 + i);
         step();
         check_state($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_err, vecs[i].e_sb,
                     vecs[i].e_db, vecs[i].e_ft, vecs[i].e_addr, vecs[i].e_type,
                     vecs[i].e_ovf, vecs[i].e_irq);
         check($sformatf("vec%0d small dbit_cnt", i), DW'(s_dbit_cnt), DW'(vecs[i].e_db));
      end

      // saturation: 4-bit counter holds at 15, 16-bit one keeps counting
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 300);
      step();
      check("sat clr sbit_cnt", DW'(sbit_cnt), '0);
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 8'(k), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 300 + k);
         step();
         check($sformatf("sat%0d small sbit_cnt", k), DW'(s_sbit_cnt), DW'((k > 15) ? 15 : k));
         check($sformatf("sat%0d sbit_cnt", k), DW'(sbit_cnt), DW'(k));
      end
      check_state("sat end", 1'b1, 1'b0, 16'd20, 16'd0, 16'd0, 8'h01, 2'd1, 1'b1, 1'b1);
      check("sat end small first_err_addr", DW'(s_first_err_addr), DW'(8'h01));

      // asynchronous reset in mid-cycle while CAPTURED
      drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 400);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 401);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 402);
      step();
      check_state("post_rst", 1'b1, 1'b1, 16'd0, 16'd1, 16'd0, 8'h66, 2'd2, 1'b0, 1'b1);
      drive(1'b1, 8'h67, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 403);
      step();
      check_state("post_rst2", 1'b1, 1'b0, 16'd1, 16'd1, 16'd0, 8'h66, 2'd2, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 404);
      step();
      check_state("post_rst idle", 1'b0, 1'b0, 16'd1, 16'd1, 16'd0, 8'h66, 2'd2, 1'b1, 1'b1);

      // final report
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
